// File: rtl/branch_unit_bht.sv
// branch_unit_bht: EX branch resolution with a 2-bit saturating-counter BHT
// for IF prediction, misprediction flagging and saturating perf counters.
module branch_unit_bht #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int IDX_LSB   = 2,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_pred_taken,
    input  logic             ex_valid,
    input  logic [2:0]       ex_branch_type,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_op1,
    input  logic [XLEN-1:0]  ex_op2,
    input  logic             ex_pred_taken,
    output logic             ex_taken,
    output logic             ex_mispredict,
    input  logic             bht_clear,
    input  logic             perf_clear,
    output logic [CNT_W-1:0] perf_br_cnt,
    output logic [CNT_W-1:0] perf_miss_cnt
);
    localparam int IW = $clog2(BHT_DEPTH);

    logic [1:0]    bht [BHT_DEPTH];
    logic          is_br, cond, eq, lt, ltu;
    logic [IW-1:0] rd_idx, wr_idx;
    logic [1:0]    cur;

    assign rd_idx = if_pc[IDX_LSB +: IW];
    assign wr_idx = ex_pc[IDX_LSB +: IW];
    assign eq     = ex_op1 == ex_op2;
    assign lt     = $signed(ex_op1) < $signed(ex_op2);
    assign ltu    = ex_op1 < ex_op2;
    assign is_br  = ex_valid && ex_branch_type != 3'd0 && ex_branch_type != 3'd7;
    assign cur    = bht[wr_idx];

    always_comb begin
        cond = ex_branch_type == 3'd1 ? eq :
               ex_branch_type == 3'd2 ? !eq :
               ex_branch_type == 3'd3 ? lt :
               ex_branch_type == 3'd4 ? ltu :
               ex_branch_type == 3'd5 ? !lt :
               ex_branch_type == 3'd6 ? !ltu : 1'b0;
    end

    assign ex_taken      = is_br && cond;
    assign ex_mispredict = is_br && (ex_taken != ex_pred_taken);
    assign if_pred_taken = bht[rd_idx][1];

    // Clear wins over a same-cycle update; no read bypass of the written entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
        end else if (bht_clear) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
        end else if (is_br) begin
            bht[wr_idx] <= ex_taken ? (cur == 2'b11 ? cur : cur + 2'b01)
                                    : (cur == 2'b00 ? cur : cur - 2'b01);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_br_cnt   <= '0;
            perf_miss_cnt <= '0;
        end else if (perf_clear) begin
            perf_br_cnt   <= '0;
            perf_miss_cnt <= '0;
        end else begin
            if (is_br && !(&perf_br_cnt)) perf_br_cnt <= perf_br_cnt + 1'b1;
            if (ex_mispredict && !(&perf_miss_cnt)) perf_miss_cnt <= perf_miss_cnt + 1'b1;
        end
    end
endmodule

// File: doc/branch_unit_bht.md
Name: branch_unit_bht

Overview:
- Parametrised successor to the single-cycle branch comparator.
- Resolves all RV32I/RV64I conditional branch types at XLEN width in EX.
- Adds a direct-mapped branch history table (BHT) of 2-bit saturating counters, giving IF a taken/not-taken prediction.
- Flags mispredictions and keeps saturating performance counters.

Parameters:
- XLEN, 32, operand and PC width.
- BHT_DEPTH, 64, BHT entries; power of two, at least 2.
- IDX_LSB, 2, lowest PC bit used for the BHT index. Index = pc[IDX_LSB +: log2(BHT_DEPTH)].
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_pc  in  XLEN  PC of the instruction being fetched.
- if_pred_taken  out  1  prediction for if_pc. Combinational read of the BHT: counter[1].
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_branch_type  in  3  0 NOBRANCH, 1 BEQ, 2 BNE, 3 BLT, 4 BLTU, 5 BGE, 6 BGEU, 7 reserved.
- ex_pc  in  XLEN  PC of the EX instruction.
- ex_op1, ex_op2  in  XLEN  rs1 and rs2 values.
- ex_pred_taken  in  1  prediction carried down the pipe for this instruction.
- ex_taken  out  1  combinational branch outcome.
- ex_mispredict  out  1  combinational; asserted when IF must be redirected.
- bht_clear  in  1  synchronous: all entries become weakly-not-taken.
- perf_clear  in  1  synchronous: both performance counters become zero.
- perf_br_cnt  out  CNT_W  resolved conditional branches.
- perf_miss_cnt  out  CNT_W  mispredicted conditional branches.

Behaviour:
- is_br = ex_valid && ex_branch_type in 1..6. Types 0 and 7 are treated as not a branch.
- Comparisons:
  - BEQ/BNE: equality.
  - BLT/BGE: signed XLEN compare, two's complement.
  - BLTU/BGEU: unsigned compare.
- ex_taken = is_br && condition. It is 0 whenever is_br is 0.
- ex_mispredict = is_br && (ex_taken != ex_pred_taken). It is 0 whenever is_br is 0.
- BHT counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction = bit1.
- Update on the clock edge when is_br is 1, at index(ex_pc):
  - taken: increment, saturating at 11.
  - not taken: decrement, saturating at 00.
- No update when is_br is 0.
- Read/write same index in one cycle: if_pred_taken shows the pre-update value. There is no bypass; the new value is visible the next cycle.
- Aliasing: PCs sharing an index share one counter. No tag check.
- bht_clear has priority over an update in the same cycle: every entry becomes 01 and the update is dropped.
- Performance counters:
  - perf_br_cnt increments on is_br.
  - perf_miss_cnt increments on ex_mispredict.
  - Both saturate at all-ones and never wrap.
  - perf_clear has priority over an increment in the same cycle.
- Reset (rst_n low, asynchronous, any time):
  - every BHT entry = 01, so if_pred_taken = 0 immediately.
  - perf_br_cnt = 0, perf_miss_cnt = 0.
  - ex_taken and ex_mispredict remain pure functions of the inputs.
- Reset asserted mid-update: the update is lost. Release is synchronised externally by the system.
- Latency: resolution and mispredict take 0 cycles (combinational). Table and counter effects appear 1 cycle after the edge.

Test Plan:
1. Reset, then if_pc=0x100 -> if_pred_taken=0. Both performance counters are 0.
2. For every type, XLEN=32: BLT op1=0xFFFFFFFF, op2=1 -> taken=1. BLTU same operands -> 0. BGE 0x80000000 vs 0x7FFFFFFF -> 0. BGEU -> 1. BEQ equal -> 1. BNE equal -> 0. Type 7 -> 0.
3. Three taken BEQ at ex_pc=0x40, ex_pred_taken=0 -> counter 01→10→11→11. ex_mispredict=1,0,0 after predictions track bit1; perf_br_cnt=3, perf_miss_cnt=1. Then if_pc=0x40 -> 1, and if_pc=0x140 (alias, DEPTH=64) -> 1.
4. Same-cycle update and read at index of 0x40 from weak-NT -> if_pred_taken=0 that cycle, 1 the next.
5. bht_clear with a simultaneous taken update -> entry reads 01. perf_clear with is_br -> perf_br_cnt=0. Set CNT_W=4 and issue 20 branches -> perf_br_cnt=15.
6. Assert rst_n low between edges after training an entry to 11 -> if_pred_taken falls to 0 without a clock edge; counters read 0.
